// File: rtl/conversor_bin_bcd_display_if.sv
// Bus between the datapath output register and the BCD converter.
// The master drives the conversion request, the slave returns the digits and status.
interface conversor_bin_bcd_display_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      valor;
  logic                  apagar_zeros;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;

  modport master (
    output start, valor, apagar_zeros,
    input  bcd, busy, done
  );

  modport slave (
    input  start, valor, apagar_zeros,
    output bcd, busy, done
  );
endinterface

// File: rtl/conversor_bin_bcd_display.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding the per-digit seven-segment decoders. Leading zeros can be forced
// to 4'hF, which the decoders show as a dark digit.
//
// state | meaning
// IDLE  | waiting for start; bcd holds the last result
// SHIFT | one add-3/shift step per clock, WIDTH steps in total
// FIM   | publish the BCD field (with optional blanking), pulse done
module conversor_bin_bcd_display #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic clock,
  input  logic reset,
  conversor_bin_bcd_display_if.slave bus
);
  localparam int SR_W  = 4*DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FIM} state_t;

  state_t              state, state_nxt;
  logic [SR_W-1:0]     sr, sr_adj, sr_sh;
  logic [CNT_W-1:0]    cnt;
  logic                blank_q;
  logic                busy_q, done_q;
  logic [4*DIGITS-1:0] bcd_q, bcd_pub;
  logic                load, shift_en, publish;
  logic                leading;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIM;
      end
      FIM: begin
        publish   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add 3 to every BCD nibble >= 5 (pre-shift values, all in parallel), then shift
  always_comb begin
    sr_adj = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr[WIDTH+4*d +: 4] >= 4'd5)
        sr_adj[WIDTH+4*d +: 4] = sr[WIDTH+4*d +: 4] + 4'd3;
    end
    sr_sh = sr_adj << 1;
  end

  // Leading-zero blanking from the top digit down; digit 0 always stays visible
  always_comb begin
    bcd_pub = sr[WIDTH +: 4*DIGITS];
    leading = blank_q;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (leading && (sr[WIDTH+4*d +: 4] == 4'd0)) bcd_pub[4*d +: 4] = 4'hF;
      else                                          leading = 1'b0;
    end
  end

  // Datapath: shift register, bit counter, captured options and published outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      cnt     <= '0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '1;
    end else begin
      done_q <= publish;
      if (load) begin
        sr      <= {{(4*DIGITS){1'b0}}, bus.valor};
        blank_q <= bus.apagar_zeros;
        cnt     <= '0;
        busy_q  <= 1'b1;
      end else if (shift_en) begin
        sr  <= sr_sh;
        cnt <= cnt + CNT_W'(1);
      end
      if (publish) begin
        bcd_q  <= bcd_pub;
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_conversor_bin_bcd_display.sv
// Self-checking bench for conversor_bin_bcd_display (WIDTH=16, DIGITS=5).
module tb_conversor_bin_bcd_display;
  logic clock;
  logic reset;
  int   tests;
  int   failed;

  conversor_bin_bcd_display_if #(.WIDTH(16), .DIGITS(5)) bus ();

  conversor_bin_bcd_display #(.WIDTH(16), .DIGITS(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] v;
    logic        bl;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, blanking by decimal digit count
  function automatic logic [19:0] ref_bcd(input int unsigned v, input logic bl);
    int unsigned x;
    int          nd;
    logic [19:0] r;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    nd = 1;
    x  = v;
    while (x >= 10) begin
      nd++;
      x = x / 10;
    end
    if (bl) for (int d = nd; d < 5; d++) r[4*d +: 4] = 4'hF;
    return r;
  endfunction

  // One full conversion with timing checks; inputs are scrambled once accepted
  task automatic convert(input logic [15:0] v, input logic bl, output logic [19:0] res);
    int          lat;
    bit          ok;
    bit          seen;
    logic [19:0] prev;
    prev             = bus.bcd;
    bus.start        = 1'b1;
    bus.valor        = v;
    bus.apagar_zeros = bl;
    tick();
    bus.start        = 1'b0;
    bus.valor        = 16'($urandom);
    bus.apagar_zeros = 1'($urandom);
    ok   = (bus.busy === 1'b1) && (bus.done === 1'b0) && (bus.bcd === prev);
    lat  = 0;
    seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      tick();
      lat = c;
      if (bus.done === 1'b1) seen = 1;
      else if (!((bus.busy === 1'b1) && (bus.done === 1'b0) && (bus.bcd === prev))) ok = 0;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'd17);
    check("busy_window", 32'(ok), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    res = bus.bcd;
    tick();
    check("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [19:0] res;
    logic [19:0] got;
    logic [15:0] rv;
    logic        rb;
    logic [19:0] exp;
    int          nd;
    int          dc;
    int          bad;
    logic [15:0] tvals[4];
    logic [19:0] texp[4];
    logic [19:0] tres[4];
    int          tcyc[4];

    tests  = 0;
    failed = 0;

    vecs[0] = '{16'd0,     1'b1, 20'hFFFF0};
    vecs[1] = '{16'd305,   1'b1, 20'hFF305};
    vecs[2] = '{16'd305,   1'b0, 20'h00305};
    vecs[3] = '{16'd65535, 1'b0, 20'h65535};
    vecs[4] = '{16'd7,     1'b0, 20'h00007};
    vecs[5] = '{16'd1000,  1'b1, 20'hF1000};
    vecs[6] = '{16'd9,     1'b1, 20'hFFFF9};
    vecs[7] = '{16'd10000, 1'b1, 20'h10000};
    vecs[8] = '{16'd0,     1'b0, 20'h00000};

    tvals = '{16'd9, 16'd10, 16'd99, 16'd100};
    texp  = '{20'h00009, 20'h00010, 20'h00099, 20'h00100};
    tres  = '{20'h0, 20'h0, 20'h0, 20'h0};
    tcyc  = '{0, 0, 0, 0};

    bus.start        = 1'b0;
    bus.valor        = '0;
    bus.apagar_zeros = 1'b0;
    reset            = 1'b1;
    #1;
    check("reset_bcd", 32'(bus.bcd), 32'hFFFFF);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      convert(vecs[i].v, vecs[i].bl, res);
      check($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].exp));
    end

    // Reset in the middle of a conversion
    bus.start = 1'b1;
    bus.valor = 16'd1234;
    bus.apagar_zeros = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check("midreset_bcd", 32'(bus.bcd), 32'hFFFFF);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.done === 1'b1) nd++;
    end
    check("no_done_after_reset", 32'(nd), 32'd0);
    check("idle_after_reset", 32'(bus.busy), 32'd0);
    convert(16'd7, 1'b0, res);
    check("after_reset_bcd", 32'(res), 32'h00007);

    // Start held high: back-to-back conversions, inputs scrambled while busy
    bus.valor        = tvals[0];
    bus.apagar_zeros = 1'b0;
    bus.start        = 1'b1;
    nd = 0;
    for (int c = 1; c <= 120 && nd < 4; c++) begin
      tick();
      if (bus.done === 1'b1) begin
        tres[nd] = bus.bcd;
        tcyc[nd] = c;
        nd++;
        if (nd < 4) begin
          bus.valor        = tvals[nd];
          bus.apagar_zeros = 1'b0;
        end else begin
          bus.start = 1'b0;
        end
      end else if (bus.busy === 1'b1) begin
        bus.valor        = 16'($urandom);
        bus.apagar_zeros = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    check("thr_count", 32'(nd), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("thr_res%0d", i), 32'(tres[i]), 32'(texp[i]));
    for (int i = 1; i < 4; i++) check($sformatf("thr_space%0d", i), 32'(tcyc[i] - tcyc[i-1]), 32'd18);
    tick();

    // Start pulses while busy are ignored
    bus.start        = 1'b1;
    bus.valor        = 16'd42;
    bus.apagar_zeros = 1'b0;
    tick();
    nd  = 0;
    dc  = 0;
    got = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5 || c == 17) begin
        bus.start = 1'b1;
        bus.valor = 16'd999;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done === 1'b1) begin
        nd++;
        dc  = c;
        got = bus.bcd;
      end
    end
    check("busy_start_ndone", 32'(nd), 32'd1);
    check("busy_start_cycle", 32'(dc), 32'd17);
    check("busy_start_bcd", 32'(got), 32'h00042);
    check("busy_start_idle", 32'(bus.busy), 32'd0);

    // Random sweep against the decimal reference
    for (int i = 0; i < 500; i++) begin
      rv  = (i % 4 == 0) ? 16'($urandom_range(0, 999)) : 16'($urandom);
      rb  = 1'($urandom);
      exp = ref_bcd(32'(rv), rb);
      convert(rv, rb, res);
      check($sformatf("rand_%0d_%0d", rv, rb), 32'(res), 32'(exp));
      bad = 0;
      for (int d = 0; d < 5; d++) begin
        got = res >> (4*d);
        if (got[3:0] > 4'd9 && got[3:0] != 4'hF) bad++;
      end
      check("rand_nibble_range", 32'(bad), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
